// File: rtl/pkg_dtypes.sv
// Shared datapath types for the front end and dispatch, including the
// instruction-queue entry format and its pointer/count widths.
package pkg_dtypes;

    localparam int LOG2_IQUEUE_DEPTH = 3;

    typedef logic [LOG2_IQUEUE_DEPTH-1:0] type_iqueue_ptr;
    typedef logic [LOG2_IQUEUE_DEPTH:0]   type_iqueue_count;

    typedef enum logic [2:0] {
        IQ_OP_ALU = 3'd0,
        IQ_OP_MUL = 3'd1,
        IQ_OP_LD  = 3'd2,
        IQ_OP_ST  = 3'd3,
        IQ_OP_BR  = 3'd4
    } type_iqueue_opclass;

    // Renamed operand block; uid tags the instruction through the backend.
    typedef struct packed {
        logic [7:0] uid;
        logic [5:0] rd;
        logic [5:0] rs1;
        logic [5:0] rs2;
    } type_iqueue_opd;

    typedef struct packed {
        type_iqueue_opclass op_class;
        logic [2:0]         funct3;
        logic [31:0]        imm;
        type_iqueue_opd     opd;
        logic [31:0]        pc;
    } type_iqueue_entry;

endpackage

// File: rtl/iqueue_fifo_mem.sv
// Entry storage for the instruction queue: one synchronous write port and
// one asynchronous read port, no reset and no control logic.
module iqueue_fifo_mem #(
    parameter int LOG2_DEPTH  = 3,
    parameter int ENTRY_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   wr_en,
    input  logic [LOG2_DEPTH-1:0]  wr_addr,
    input  logic [ENTRY_WIDTH-1:0] wr_data,
    input  logic [LOG2_DEPTH-1:0]  rd_addr,
    output logic [ENTRY_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 2 ** LOG2_DEPTH;

    logic [ENTRY_WIDTH-1:0] mem_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_reg[wr_addr] <= wr_data;
        end
    end

    // Combinational read keeps the head visible in the same cycle (fall-through).
    assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/iqueue_fifo.sv
// Instruction queue between decode/rename and dispatch: circular buffer with
// valid/ready on both sides, flush on mispredict, occupancy and almost-full.
module iqueue_fifo
    import pkg_dtypes::*;
#(
    parameter int LOG2_DEPTH         = 3,
    parameter int ENTRY_WIDTH        = $bits(type_iqueue_entry),
    parameter int ALMOST_FULL_THRESH = (2 ** LOG2_DEPTH) - 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_flush,
    input  logic                   i_wr_valid,
    output logic                   o_wr_ready,
    input  logic [ENTRY_WIDTH-1:0] i_wr_entry,
    output logic                   o_rd_valid,
    input  logic                   i_rd_ready,
    output logic [ENTRY_WIDTH-1:0] o_rd_entry,
    output logic [LOG2_DEPTH:0]    o_count,
    output logic                   o_almost_full,
    output logic                   o_empty
);

    localparam logic [LOG2_DEPTH:0] DEPTH_CNT  = {1'b1, {LOG2_DEPTH{1'b0}}};
    localparam logic [LOG2_DEPTH:0] AF_THRESH  = ALMOST_FULL_THRESH[LOG2_DEPTH:0];
    localparam logic [LOG2_DEPTH:0] COUNT_ONE  = {{LOG2_DEPTH{1'b0}}, 1'b1};
    localparam logic [LOG2_DEPTH-1:0] PTR_ONE  = {{(LOG2_DEPTH-1){1'b0}}, 1'b1};

    logic [LOG2_DEPTH-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [LOG2_DEPTH-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [LOG2_DEPTH:0]    count_reg, count_next;
    logic                   push;
    logic                   pop;
    logic                   mem_wr_en;
    logic [ENTRY_WIDTH-1:0] mem_rd_data;

    // Ready and valid come only from the registered count, so neither side
    // sees a combinational path from the other's handshake input.
    assign o_wr_ready = (count_reg != DEPTH_CNT);
    assign o_rd_valid = (count_reg != '0);

    assign push      = i_wr_valid & o_wr_ready;
    assign pop       = o_rd_valid & i_rd_ready;
    assign mem_wr_en = push & ~i_flush;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (i_flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + COUNT_ONE;
                2'b01:   count_next = count_reg - COUNT_ONE;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    iqueue_fifo_mem #(
        .LOG2_DEPTH  (LOG2_DEPTH),
        .ENTRY_WIDTH (ENTRY_WIDTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (mem_wr_en),
        .wr_addr (wr_ptr_reg),
        .wr_data (i_wr_entry),
        .rd_addr (rd_ptr_reg),
        .rd_data (mem_rd_data)
    );

    // Storage is never reset, so the head is masked to zero while empty.
    assign o_rd_entry    = o_rd_valid ? mem_rd_data : '0;
    assign o_count       = count_reg;
    assign o_empty       = (count_reg == '0);
    assign o_almost_full = (count_reg >= AF_THRESH);

endmodule

// File: tb/tb_iqueue_fifo.sv
// Directed self-checking bench for iqueue_fifo at LOG2_DEPTH=3.
module tb_iqueue_fifo;
    import pkg_dtypes::*;

    localparam int LOG2_DEPTH = 3;
    localparam int EW         = $bits(type_iqueue_entry);

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  i_flush;
    logic                  i_wr_valid;
    logic                  o_wr_ready;
    type_iqueue_entry      i_wr_entry;
    logic                  o_rd_valid;
    logic                  i_rd_ready;
    logic [EW-1:0]         o_rd_entry;
    logic [LOG2_DEPTH:0]   o_count;
    logic                  o_almost_full;
    logic                  o_empty;

    int checks = 0;
    int errors = 0;

    iqueue_fifo #(.LOG2_DEPTH(LOG2_DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_flush       (i_flush),
        .i_wr_valid    (i_wr_valid),
        .o_wr_ready    (o_wr_ready),
        .i_wr_entry    (i_wr_entry),
        .o_rd_valid    (o_rd_valid),
        .i_rd_ready    (i_rd_ready),
        .o_rd_entry    (o_rd_entry),
        .o_count       (o_count),
        .o_almost_full (o_almost_full),
        .o_empty       (o_empty)
    );

    always #5 clk = ~clk;

    function automatic type_iqueue_entry make_entry(input int uid);
        type_iqueue_entry e;
        e.op_class = type_iqueue_opclass'(3'(uid % 5));
        e.funct3   = 3'(uid + 1);
        e.imm      = 32'hA500_0000 + 32'(uid);
        e.opd.uid  = 8'(uid);
        e.opd.rd   = 6'(uid + 2);
        e.opd.rs1  = 6'(uid + 3);
        e.opd.rs2  = 6'(uid + 4);
        e.pc       = 32'h0000_1000 + 32'(uid * 4);
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; i_flush = 1'b0; i_wr_valid = 1'b0; i_rd_ready = 1'b0;
        i_wr_entry = '0;
        step(); step();
        reset = 1'b0;
        step();
        checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", o_empty); end
        checks++; if (o_wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %b want 1", o_wr_ready); end
        checks++; if (o_rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b want 0", o_rd_valid); end
        checks++; if (o_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", o_count); end
        checks++; if (o_almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost_full got %b want 0", o_almost_full); end
        checks++; if (o_rd_entry !== '0) begin errors++; $display("FAIL reset_rd_entry got %h want 0", o_rd_entry); end
        $display("test_reset done count=%0d", o_count);
    endtask

    task automatic test_async_reset();
        i_wr_valid = 1'b1; i_rd_ready = 1'b0;
        for (int u = 0; u < 5; u++) begin
            i_wr_entry = make_entry(100 + u);
            step();
        end
        i_wr_valid = 1'b0;
        checks++; if (o_count !== 4'd5) begin errors++; $display("FAIL async_pre_count got %0d want 5", o_count); end
        #2 reset = 1'b1;
        #1;
        checks++; if (o_count !== 4'd0) begin errors++; $display("FAIL async_reset_count got %0d want 0", o_count); end
        checks++; if (o_rd_valid !== 1'b0) begin errors++; $display("FAIL async_reset_rd_valid got %b want 0", o_rd_valid); end
        reset = 1'b0;
        step();
        checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL async_after_empty got %b want 1", o_empty); end
        $display("test_async_reset done count=%0d", o_count);
    endtask

    task automatic test_fill();
        i_wr_valid = 1'b1; i_rd_ready = 1'b0;
        for (int u = 0; u < 8; u++) begin
            i_wr_entry = make_entry(u);
            checks++; if (o_wr_ready !== 1'b1) begin errors++; $display("FAIL fill_wr_ready_%0d got %b want 1", u, o_wr_ready); end
            step();
            checks++; if (o_count !== 4'(u + 1)) begin errors++; $display("FAIL fill_count got %0d want %0d", o_count, u + 1); end
            checks++; if (o_almost_full !== (u + 1 >= 6)) begin errors++; $display("FAIL fill_almost_full at %0d got %b want %b", u + 1, o_almost_full, (u + 1 >= 6)); end
            $display("push uid=%0d count=%0d af=%b", u, o_count, o_almost_full);
        end
        checks++; if (o_wr_ready !== 1'b0) begin errors++; $display("FAIL full_wr_ready got %b want 0", o_wr_ready); end
        i_wr_entry = make_entry(8);
        step(); step();
        checks++; if (o_count !== 4'd8) begin errors++; $display("FAIL held_push_count got %0d want 8", o_count); end
        checks++; if (o_rd_entry !== make_entry(0)) begin errors++; $display("FAIL full_head got %h want %h", o_rd_entry, make_entry(0)); end
    endtask

    task automatic test_full_push_pop();
        i_wr_valid = 1'b1; i_wr_entry = make_entry(8); i_rd_ready = 1'b1;
        step();
        checks++; if (o_count !== 4'd7) begin errors++; $display("FAIL full_pp_count got %0d want 7", o_count); end
        checks++; if (o_wr_ready !== 1'b1) begin errors++; $display("FAIL full_pp_wr_ready got %b want 1", o_wr_ready); end
        checks++; if (o_rd_entry !== make_entry(1)) begin errors++; $display("FAIL full_pp_head got %h want %h", o_rd_entry, make_entry(1)); end
        i_rd_ready = 1'b0;
        step();
        checks++; if (o_count !== 4'd8) begin errors++; $display("FAIL full_pp_accept got %0d want 8", o_count); end
        i_wr_valid = 1'b0; i_rd_ready = 1'b1;
        for (int u = 1; u <= 8; u++) begin
            checks++; if (o_rd_valid !== 1'b1 || o_rd_entry !== make_entry(u)) begin errors++; $display("FAIL drain_uid got %h want %h", o_rd_entry, make_entry(u)); end
            $display("pop uid=%0d", u);
            step();
        end
        i_rd_ready = 1'b0;
        checks++; if (o_empty !== 1'b1 || o_count !== 4'd0) begin errors++; $display("FAIL drain_empty got count %0d want 0", o_count); end
    endtask

    task automatic test_wrap();
        i_wr_valid = 1'b1; i_rd_ready = 1'b0;
        for (int u = 20; u < 23; u++) begin
            i_wr_entry = make_entry(u);
            step();
        end
        i_rd_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            i_wr_entry = make_entry(23 + k);
            checks++; if (o_rd_entry !== make_entry(20 + k)) begin errors++; $display("FAIL wrap_order got %h want %h", o_rd_entry, make_entry(20 + k)); end
            step();
            checks++; if (o_count !== 4'd3) begin errors++; $display("FAIL wrap_count got %0d want 3", o_count); end
            $display("pair push uid=%0d pop uid=%0d count=%0d", 23 + k, 20 + k, o_count);
        end
        i_wr_valid = 1'b0;
        for (int u = 40; u < 43; u++) begin
            checks++; if (o_rd_entry !== make_entry(u)) begin errors++; $display("FAIL wrap_tail got %h want %h", o_rd_entry, make_entry(u)); end
            step();
        end
        i_rd_ready = 1'b0;
        checks++; if (o_count !== 4'd0) begin errors++; $display("FAIL wrap_final_count got %0d want 0", o_count); end
    endtask

    task automatic test_flush();
        i_wr_valid = 1'b1; i_rd_ready = 1'b0;
        for (int u = 50; u < 55; u++) begin
            i_wr_entry = make_entry(u);
            step();
        end
        checks++; if (o_count !== 4'd5) begin errors++; $display("FAIL flush_pre_count got %0d want 5", o_count); end
        i_wr_entry = make_entry(9); i_flush = 1'b1;
        step();
        i_flush = 1'b0; i_wr_valid = 1'b0;
        checks++; if (o_count !== 4'd0) begin errors++; $display("FAIL flush_count got %0d want 0", o_count); end
        checks++; if (o_rd_valid !== 1'b0) begin errors++; $display("FAIL flush_rd_valid got %b want 0", o_rd_valid); end
        step();
        checks++; if (o_rd_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped_push got %b want 0", o_rd_valid); end
        i_wr_valid = 1'b1; i_wr_entry = make_entry(60);
        step();
        i_wr_valid = 1'b0;
        checks++; if (o_rd_entry !== make_entry(60)) begin errors++; $display("FAIL flush_after_head got %h want %h", o_rd_entry, make_entry(60)); end
        i_rd_ready = 1'b1;
        step();
        i_rd_ready = 1'b0;
        checks++; if (o_count !== 4'd0) begin errors++; $display("FAIL flush_after_pop got %0d want 0", o_count); end
        $display("test_flush done count=%0d", o_count);
    endtask

    task automatic test_push_empty_ready();
        i_wr_valid = 1'b1; i_wr_entry = make_entry(70); i_rd_ready = 1'b1;
        #3;
        checks++; if (o_rd_valid !== 1'b0) begin errors++; $display("FAIL nobypass_rd_valid got %b want 0", o_rd_valid); end
        step();
        i_wr_valid = 1'b0;
        checks++; if (o_rd_valid !== 1'b1) begin errors++; $display("FAIL pe_visible got %b want 1", o_rd_valid); end
        checks++; if (o_rd_entry !== make_entry(70)) begin errors++; $display("FAIL pe_entry got %h want %h", o_rd_entry, make_entry(70)); end
        checks++; if (o_count !== 4'd1) begin errors++; $display("FAIL pe_count got %0d want 1", o_count); end
        step();
        i_rd_ready = 1'b0;
        checks++; if (o_count !== 4'd0 || o_rd_valid !== 1'b0) begin errors++; $display("FAIL pe_popped got count %0d want 0", o_count); end
        $display("test_push_empty_ready done count=%0d", o_count);
    endtask

    initial begin
        test_reset();
        test_async_reset();
        test_fill();
        test_full_push_pop();
        test_wrap();
        test_flush();
        test_push_empty_ready();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
